// File: rtl/apb_pkg.sv
// Shared APB definitions: response encodings used by every APB slave.
package apb_pkg;

    // PSLVERR encodings.
    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

endpackage : apb_pkg

// File: rtl/apb_regs.sv
// apb_regs: a bank of NO_APB_REGS registers behind a zero-wait-state APB slave.
// Registers sit at base_addr_i + i*ADDR_OFFSET. Read-only registers have no
// storage and simply mirror reg_init_i. Writable registers reset to reg_init_i
// and accept byte-strobed writes in the APB access cycle.
module apb_regs
    import apb_pkg::*;
#(
    parameter int unsigned NO_APB_REGS    = 32'd1,
    parameter int unsigned ADDR_OFFSET    = 32'd4,
    parameter int unsigned APB_ADDR_WIDTH = 32'd32,
    parameter int unsigned APB_DATA_WIDTH = 32'd32,
    parameter int unsigned REG_DATA_WIDTH = 32'd32,
    parameter logic [NO_APB_REGS-1:0] READ_ONLY = '0,
    localparam int unsigned STRB_W = (APB_DATA_WIDTH + 32'd7) / 32'd8
) (
    input  logic                                        pclk_i,
    input  logic                                        preset_i,
    input  logic [APB_ADDR_WIDTH-1:0]                   paddr_i,
    input  logic [2:0]                                  pprot_i,
    input  logic                                        psel_i,
    input  logic                                        penable_i,
    input  logic                                        pwrite_i,
    input  logic [APB_DATA_WIDTH-1:0]                   pwdata_i,
    input  logic [STRB_W-1:0]                           pstrb_i,
    output logic                                        pready_o,
    output logic [APB_DATA_WIDTH-1:0]                   prdata_o,
    output logic                                        pslverr_o,
    input  logic [APB_ADDR_WIDTH-1:0]                   base_addr_i,
    input  logic [NO_APB_REGS-1:0][REG_DATA_WIDTH-1:0]  reg_init_i,
    output logic [NO_APB_REGS-1:0][REG_DATA_WIDTH-1:0]  reg_q_o
);

    // Register stride is a power of two, so the index is a plain shift and
    // the low offset bits drop out (unaligned addresses hit the floor register).
    localparam int unsigned OFF_SHIFT = $clog2(ADDR_OFFSET);
    localparam int unsigned IDX_W     = (NO_APB_REGS > 1) ? $clog2(NO_APB_REGS) : 1;
    localparam logic [APB_ADDR_WIDTH-1:0] NUM_REGS = APB_ADDR_WIDTH'(NO_APB_REGS);

    if (REG_DATA_WIDTH > APB_DATA_WIDTH) begin : g_width_check
        $error("apb_regs: REG_DATA_WIDTH must not exceed APB_DATA_WIDTH");
    end

    logic [APB_ADDR_WIDTH-1:0] addr_off;
    logic [APB_ADDR_WIDTH-1:0] reg_idx;
    logic                      addr_hit;
    logic [IDX_W-1:0]          sel_idx;
    logic                      sel_ro;
    logic                      wr_access;
    logic [REG_DATA_WIDTH-1:0] wr_mask;
    logic [REG_DATA_WIDTH-1:0] wr_data;

    // Address decode.
    assign addr_off = paddr_i - base_addr_i;
    assign reg_idx  = addr_off >> OFF_SHIFT;
    assign addr_hit = (paddr_i >= base_addr_i) && (reg_idx < NUM_REGS);
    assign sel_idx  = reg_idx[IDX_W-1:0];
    assign sel_ro   = addr_hit && READ_ONLY[sel_idx];

    // Zero wait states: every transfer completes in its access cycle.
    assign pready_o = 1'b1;

    // A write commits only in the access phase, to a decoded writable register.
    assign wr_access = psel_i && penable_i && pwrite_i && addr_hit && !sel_ro;
    assign wr_data   = pwdata_i[REG_DATA_WIDTH-1:0];

    // Expand byte strobes to a per-bit write mask; strobes above the register width are dropped.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned, which would infer a latch.
        wr_mask = '0;
        for (int j = 0; j < int'(REG_DATA_WIDTH); j++) begin
            wr_mask[j] = pstrb_i[j/8];
        end
    end

    // Read data and error response, combinational from the current request.
    always_comb begin
        prdata_o  = '0;
        pslverr_o = RESP_OKAY;
        if (psel_i) begin
            if (!addr_hit) begin
                pslverr_o = RESP_SLVERR;
            end else begin
                prdata_o = APB_DATA_WIDTH'(reg_q_o[sel_idx]);
                if (pwrite_i && sel_ro) begin
                    pslverr_o = RESP_SLVERR;
                end
            end
        end
    end

    for (genvar i = 0; i < int'(NO_APB_REGS); i++) begin : g_reg
        if (READ_ONLY[i]) begin : g_ro
            assign reg_q_o[i] = reg_init_i[i];
        end else begin : g_rw
            logic [REG_DATA_WIDTH-1:0] q;

            // Register storage: reset to its init value, merge strobed bytes on a write hit.
            always_ff @(posedge pclk_i or posedge preset_i) begin
                // NOTE: the reset value is a port, not a constant; reg_init_i must be stable while preset_i is high.
                if (preset_i) begin
                    q <= reg_init_i[i];
                end else if (wr_access && (sel_idx == IDX_W'(i))) begin
                    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
                    q <= (q & ~wr_mask) | (wr_data & wr_mask);
                end
            end

            assign reg_q_o[i] = q;
        end
    end

    // Inputs and decode bits that carry no information for this block.
    logic unused_ok;
    assign unused_ok = ^{pprot_i, pwdata_i, pstrb_i, addr_off, reg_idx};

endmodule : apb_regs

// File: tb/tb_apb_regs.sv
// Directed and randomized checks for apb_regs against a small golden model.
module tb_apb_regs;

    localparam int unsigned N  = 342;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 27;
    localparam int unsigned RW = 16;
    localparam int unsigned SW = 4;
    localparam logic [N-1:0]  RO   = 342'hFFF0;
    localparam logic [AW-1:0] BASE = 32'h0003_0000;

    logic              pclk;
    logic              preset;
    logic [AW-1:0]     paddr;
    logic [2:0]        pprot;
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [DW-1:0]     pwdata;
    logic [SW-1:0]     pstrb;
    logic              pready;
    logic [DW-1:0]     prdata;
    logic              pslverr;
    logic [AW-1:0]     base_addr;
    logic [N-1:0][RW-1:0] reg_init;
    logic [N-1:0][RW-1:0] reg_q;

    logic [RW-1:0] model [N];
    int tests = 0;
    int fails = 0;

    apb_regs #(
        .NO_APB_REGS   (N),
        .ADDR_OFFSET   (4),
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .REG_DATA_WIDTH(RW),
        .READ_ONLY     (RO)
    ) dut (
        .pclk_i     (pclk),
        .preset_i   (preset),
        .paddr_i    (paddr),
        .pprot_i    (pprot),
        .psel_i     (psel),
        .penable_i  (penable),
        .pwrite_i   (pwrite),
        .pwdata_i   (pwdata),
        .pstrb_i    (pstrb),
        .pready_o   (pready),
        .prdata_o   (prdata),
        .pslverr_o  (pslverr),
        .base_addr_i(base_addr),
        .reg_init_i (reg_init),
        .reg_q_o    (reg_q)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Golden decode: hit when at/after base and the word index is in range.
    function automatic bit m_hit(input logic [31:0] a, output int idx);
        logic [31:0] off;
        off = a - BASE;
        idx = int'(off >> 2);
        return (a >= BASE) && ((off >> 2) < N);
    endfunction

    function automatic bit m_ro(input int idx);
        return (idx >= 4) && (idx <= 15);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(N); i++) model[i] = reg_init[i];
    endtask

    // One full APB transfer (setup + access), checked against the model.
    task automatic xfer(input string tag, input logic wr, input logic [31:0] a,
                        input logic [26:0] d, input logic [3:0] s);
        int  idx;
        bit  hit;
        logic [31:0] exp_rd;
        hit    = m_hit(a, idx);
        exp_rd = hit ? 32'(model[idx]) : 32'h0;
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
        @(negedge pclk);
        penable = 1'b1;
        #1;
        check({tag, ".pslverr"}, 32'(pslverr), 32'(!hit || (wr && m_ro(idx))));
        check({tag, ".pready"}, 32'(pready), 32'h1);
        if (!wr) check({tag, ".prdata"}, 32'(prdata), exp_rd);
        if (wr && hit && !m_ro(idx)) begin
            if (s[0]) model[idx][7:0]  = d[7:0];
            if (s[1]) model[idx][15:8] = d[15:8];
        end
        @(posedge pclk);
        #1;
        if (wr && hit) check({tag, ".reg_q"}, 32'(reg_q[idx]), 32'(model[idx]));
    endtask

    task automatic idle();
        @(negedge pclk);
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    initial begin
        pclk = 1'b0; preset = 1'b0; pprot = 3'b000;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0;
        base_addr = BASE;
        for (int i = 0; i < int'(N); i++) reg_init[i] = 16'hA000 + 16'(i);
        model_reset();

        // Reset state
        #2 preset = 1'b1;
        #1;
        check("rst.reg0", 32'(reg_q[0]), 32'hA000);
        check("rst.reg4_ro", 32'(reg_q[4]), 32'hA004);
        check("rst.reg341", 32'(reg_q[341]), 32'hA155);
        check("rst.pready", 32'(pready), 32'h1);
        check("rst.prdata_idle", 32'(prdata), 32'h0);
        check("rst.pslverr_idle", 32'(pslverr), 32'h0);
        @(negedge pclk);
        preset = 1'b0;

        // Full write of zero to reg 0, then unaligned read back
        xfer("w0", 1'b1, 32'h30000, 27'h0, 4'hF);
        check("w0.value", 32'(reg_q[0]), 32'h0000);
        xfer("r0_unal", 1'b0, 32'h30002, 27'h0, 4'h0);

        // Byte strobes on reg 1
        xfer("w1_full", 1'b1, 32'h30004, 27'hABCD, 4'h3);
        check("w1_full.value", 32'(reg_q[1]), 32'hABCD);
        xfer("w1_lo", 1'b1, 32'h30004, 27'h1234, 4'h1);
        check("w1_lo.value", 32'(reg_q[1]), 32'hAB34);
        xfer("w1_hi", 1'b1, 32'h30004, 27'h5600, 4'h2);
        check("w1_hi.value", 32'(reg_q[1]), 32'h5634);
        xfer("w1_nostrb", 1'b1, 32'h30004, 27'h7FFFFFF, 4'h0);
        check("w1_nostrb.value", 32'(reg_q[1]), 32'h5634);

        // Strobes/data above the register width are ignored
        xfer("w2_upper", 1'b1, 32'h30008, 27'h7FFFFFF, 4'hC);
        check("w2_upper.value", 32'(reg_q[2]), 32'hA002);

        // Read-only register
        xfer("w4_ro", 1'b1, 32'h30010, 27'h5555, 4'hF);
        check("w4_ro.value", 32'(reg_q[4]), 32'hA004);
        xfer("r4_ro", 1'b0, 32'h30010, 27'h0, 4'h0);
        check("r4_ro.prdata_hand", 32'(prdata), 32'hA004);

        // Address boundaries
        xfer("r_below", 1'b0, 32'h2FF00, 27'h0, 4'h0);
        xfer("r_idx342", 1'b0, 32'h30558, 27'h0, 4'h0);
        xfer("r_idx341", 1'b0, 32'h30554, 27'h0, 4'h0);
        check("r_idx341.prdata_hand", 32'(prdata), 32'hA155);
        xfer("w_miss", 1'b1, 32'h30558, 27'h1111, 4'hF);

        // psel low: quiet bus
        idle();
        paddr = 32'h30558;
        #1;
        check("idle.pslverr", 32'(pslverr), 32'h0);
        check("idle.prdata", 32'(prdata), 32'h0);

        // Setup phase alone never writes
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h3000C; pwdata = 27'h7777; pstrb = 4'hF;
        @(posedge pclk);
        #1;
        check("setup_only.reg3", 32'(reg_q[3]), 32'hA003);
        idle();

        // Reset after writes: RW registers return to init immediately
        @(negedge pclk);
        preset = 1'b1;
        #1;
        for (int i = 0; i < int'(N); i++) begin
            if (!m_ro(i)) check($sformatf("rst2.reg%0d", i), 32'(reg_q[i]), 32'(reg_init[i]));
        end
        model_reset();
        @(negedge pclk);
        preset = 1'b0;

        // Reset during an access phase aborts the write
        @(negedge pclk);
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30008; pwdata = 27'h1111; pstrb = 4'h3;
        @(negedge pclk);
        penable = 1'b1; preset = 1'b1;
        @(posedge pclk);
        #1;
        check("rst_mid.reg2", 32'(reg_q[2]), 32'hA002);
        @(negedge pclk);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        xfer("after_rst", 1'b1, 32'h30008, 27'h2222, 4'h3);
        check("after_rst.value", 32'(reg_q[2]), 32'h2222);

        // Random traffic over and around the register window
        for (int k = 0; k < 24000; k++) begin
            logic [31:0] a;
            a = 32'h2FF00 + $urandom_range(0, 32'h1000);
            xfer("rand", 1'($urandom_range(0, 1)), a, 27'($urandom), 4'($urandom));
        end
        idle();

        // Final sweep of every register against the model
        for (int i = 0; i < int'(N); i++) begin
            check($sformatf("final.reg%0d", i), 32'(reg_q[i]), 32'(model[i]));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_apb_regs
